// File: rtl/wb_grf_pkg.sv
// Shared CPU constants for the write-back stage and general register file.
package wb_grf_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;
  localparam int XLEN     = 32;

  typedef enum logic [1:0] {
    WD_ALU = 2'd0,
    WD_DM  = 2'd1,
    WD_PC8 = 2'd2,
    WD_MDU = 2'd3
  } wd_sel_e;

endpackage

// File: rtl/wb_grf_if.sv
// W-stage write port, D-stage read ports and commit/trace outputs of the GRF.
interface wb_grf_if;
  import wb_grf_pkg::*;

  logic [XLEN-1:0]   w_instr;
  logic [XLEN-1:0]   w_pc;
  logic [REG_AW-1:0] w_a3;
  logic              w_we;
  wd_sel_e           w_wd_sel;
  logic [XLEN-1:0]   w_alu_result;
  logic [XLEN-1:0]   w_data;
  logic [XLEN-1:0]   w_mdu_out;
  logic              w_cond_en;
  logic              w_cond;

  logic [REG_AW-1:0] d_a1;
  logic [REG_AW-1:0] d_a2;
  logic [XLEN-1:0]   d_rd1;
  logic [XLEN-1:0]   d_rd2;

  logic              grf_we;
  logic [REG_AW-1:0] grf_a3;
  logic [XLEN-1:0]   grf_wd;
  logic [XLEN-1:0]   retire_cnt;

  // Pipeline side: drives the W-stage write and D-stage read indices.
  modport master (
    output w_instr, w_pc, w_a3, w_we, w_wd_sel, w_alu_result, w_data,
           w_mdu_out, w_cond_en, w_cond, d_a1, d_a2,
    input  d_rd1, d_rd2, grf_we, grf_a3, grf_wd, retire_cnt
  );

  modport slave (
    input  w_instr, w_pc, w_a3, w_we, w_wd_sel, w_alu_result, w_data,
           w_mdu_out, w_cond_en, w_cond, d_a1, d_a2,
    output d_rd1, d_rd2, grf_we, grf_a3, grf_wd, retire_cnt
  );

endinterface

// File: rtl/wb_wd_mux.sv
// Combinational write-data selector for the W stage.
module wb_wd_mux
  import wb_grf_pkg::*;
(
  input  wd_sel_e         sel,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] alu,
  input  logic [XLEN-1:0] data,
  input  logic [XLEN-1:0] mdu,
  output logic [XLEN-1:0] wd
);

  always_comb begin
    // NOTE: default first so every path assigns wd and no latch is inferred.
    wd = alu;
    unique case (sel)
      WD_ALU: wd = alu;
      WD_DM:  wd = data;
      WD_PC8: wd = pc + 32'd8;
      WD_MDU: wd = mdu;
      default: wd = alu;
    endcase
  end

endmodule

// File: rtl/wb_grf.sv
// Write-back stage and 31x32 general register file with write-first read bypass
// and a retired-write counter.
module wb_grf
  import wb_grf_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  wb_grf_if.slave  bus
);

  logic [XLEN-1:0] wd;
  logic            we;
  logic [XLEN-1:0] regs [1:NUM_REGS-1];
  logic [XLEN-1:0] retire_cnt_q;

  wb_wd_mux u_wd_mux (
    .sel  (bus.w_wd_sel),
    .pc   (bus.w_pc),
    .alu  (bus.w_alu_result),
    .data (bus.w_data),
    .mdu  (bus.w_mdu_out),
    .wd   (wd)
  );

  // Writes to register 0 are dropped so they neither store nor retire.
  assign we = bus.w_we & (~bus.w_cond_en | bus.w_cond) & (bus.w_a3 != '0);

  assign bus.grf_we     = we;
  assign bus.grf_a3     = bus.w_a3;
  assign bus.grf_wd     = wd;
  assign bus.retire_cnt = retire_cnt_q;

  // NOTE: the array is cleared on reset, which rules out a RAM macro; the
  // architecture requires every register to read zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      // NOTE: non-blocking so same-edge readers see the pre-edge value.
      regs[bus.w_a3] <= wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt_q <= '0;
    end else if (we) begin
      retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  // Reads ignore reset so a write in flight still forwards to the D stage.
  always_comb begin
    bus.d_rd1 = '0;
    if (bus.d_a1 != '0) begin
      if (we && (bus.d_a1 == bus.w_a3)) begin
        bus.d_rd1 = wd;
      end else begin
        bus.d_rd1 = regs[bus.d_a1];
      end
    end
  end

  always_comb begin
    bus.d_rd2 = '0;
    if (bus.d_a2 != '0) begin
      if (we && (bus.d_a2 == bus.w_a3)) begin
        bus.d_rd2 = wd;
      end else begin
        bus.d_rd2 = regs[bus.d_a2];
      end
    end
  end

endmodule

// File: tb/tb_wb_grf.sv
// Scoreboarded random and directed bench for wb_grf against an array-based model.
module tb_wb_grf;
  import wb_grf_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_grf_if bus ();

  wb_grf dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    string       tag;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;
  int          n_vec = 0;
  int          n_bad = 0;
  bit          drv_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // One cycle: drive at posedge+1, predict, then retire the model at the edge.
  task automatic step(input logic rst, input logic we, input logic [4:0] a3,
                      input logic [1:0] sel, input logic [31:0] pc, input logic [31:0] alu,
                      input logic [31:0] data, input logic [31:0] mdu,
                      input logic cen, input logic c, input logic [4:0] a1,
                      input logic [4:0] a2, input string tag);
    exp_t        e;
    logic [31:0] wd;
    logic        gwe;
    reset            = rst;
    bus.w_instr      = $urandom;
    bus.w_pc         = pc;
    bus.w_a3         = a3;
    bus.w_we         = we;
    bus.w_wd_sel     = wd_sel_e'(sel);
    bus.w_alu_result = alu;
    bus.w_data       = data;
    bus.w_mdu_out    = mdu;
    bus.w_cond_en    = cen;
    bus.w_cond       = c;
    bus.d_a1         = a1;
    bus.d_a2         = a2;
    case (sel)
      2'd0: wd = alu;
      2'd1: wd = data;
      2'd2: wd = pc + 32'd8;
      default: wd = mdu;
    endcase
    gwe   = we && (!cen || c) && (a3 != 0);
    e.tag = tag;
    e.we  = gwe;
    e.a3  = a3;
    e.wd  = wd;
    e.cnt = m_cnt;
    e.rd1 = (a1 == 0) ? 32'd0 : (gwe && a1 == a3) ? wd : m_regs[a1];
    e.rd2 = (a2 == 0) ? 32'd0 : (gwe && a2 == a3) ? wd : m_regs[a2];
    exp_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_cnt = '0;
    end else if (gwe) begin
      m_regs[a3] = wd;
      m_cnt      = m_cnt + 32'd1;
    end
    #1;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2, input string tag);
    step(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, a1, a2, tag);
  endtask

  // Monitor: compares each presented cycle against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check({e.tag, ".rd1"}, bus.d_rd1, e.rd1);
        check({e.tag, ".rd2"}, bus.d_rd2, e.rd2);
        check({e.tag, ".we"}, {31'd0, bus.grf_we}, {31'd0, e.we});
        check({e.tag, ".a3"}, {27'd0, bus.grf_a3}, {27'd0, e.a3});
        check({e.tag, ".wd"}, bus.grf_wd, e.wd);
        check({e.tag, ".cnt"}, bus.retire_cnt, e.cnt);
        if (bus.grf_we)
          $display("trace t=%0t pc=%h a3=%0d wd=%h", $time, bus.w_pc, bus.grf_a3, bus.grf_wd);
      end
    end
  end

  initial begin
    logic [4:0]  a3;
    logic [4:0]  a1;
    logic [4:0]  a2;
    foreach (m_regs[i]) m_regs[i] = '0;
    m_cnt            = '0;
    reset            = 1'b1;
    bus.w_instr      = '0;
    bus.w_pc         = '0;
    bus.w_a3         = '0;
    bus.w_we         = 1'b0;
    bus.w_wd_sel     = WD_ALU;
    bus.w_alu_result = '0;
    bus.w_data       = '0;
    bus.w_mdu_out    = '0;
    bus.w_cond_en    = 1'b0;
    bus.w_cond       = 1'b0;
    bus.d_a1         = '0;
    bus.d_a2         = '0;
    repeat (2) @(posedge clk);
    #1;

    rd(5'd1, 5'd31, "reset_state");
    step(0, 1, 5'd5, 2'd0, 32'd0, 32'h1234, 32'd0, 32'd0, 0, 0, 5'd5, 5'd5, "wr5_bypass");
    rd(5'd5, 5'd0, "rd5");
    step(0, 1, 5'd0, 2'd0, 32'd0, 32'hFFFF, 32'd0, 32'd0, 0, 0, 5'd0, 5'd5, "wr_r0");
    rd(5'd0, 5'd5, "after_r0");
    step(0, 1, 5'd31, 2'd2, 32'h3000, 32'd0, 32'd0, 32'd0, 0, 0, 5'd1, 5'd2, "pc8");
    rd(5'd31, 5'd5, "rd31");
    step(0, 1, 5'd8, 2'd1, 32'd0, 32'd0, 32'h55, 32'd0, 0, 0, 5'd0, 5'd0, "pre8");
    step(0, 1, 5'd8, 2'd1, 32'd0, 32'd0, 32'hAA, 32'd0, 1, 0, 5'd8, 5'd8, "cond0");
    step(0, 1, 5'd8, 2'd1, 32'd0, 32'd0, 32'hAA, 32'd0, 1, 1, 5'd8, 5'd8, "cond1");
    rd(5'd8, 5'd31, "rd8");
    step(0, 1, 5'd9, 2'd3, 32'd0, 32'd0, 32'd0, 32'hCAFE_F00D, 0, 0, 5'd9, 5'd8, "mdu");
    step(1, 1, 5'd3, 2'd0, 32'd0, 32'd7, 32'd0, 32'd0, 0, 0, 5'd3, 5'd3, "rst_wr");
    rd(5'd3, 5'd5, "post_rst");

    // Preload the counter to its top value, then one write must wrap it.
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    step(0, 1, 5'd4, 2'd0, 32'd0, 32'h11, 32'd0, 32'd0, 0, 0, 5'd4, 5'd0, "wrap");
    rd(5'd4, 5'd0, "after_wrap");

    for (int i = 0; i < 1000; i++) begin
      a3 = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 63) == 0), 1'($urandom), a3, 2'($urandom), $urandom,
           $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), a1, a2, "rand");
    end
    drv_done = 1;
  end

  initial begin
    int budget;
    wait (drv_done);
    budget = 0;
    while (exp_q.size() != 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
